// File: rtl/ring_pkg.sv
// ring_pkg: shared flit type and destination-field helper for the ring stop
package ring_pkg;
  localparam int FLIT_W = 8;
  localparam int ID_W = 2;
  typedef logic [FLIT_W-1:0] flit_t;
  function automatic logic [ID_W-1:0] flit_dest(flit_t f);
    return f[FLIT_W-1 -: ID_W];
  endfunction
endpackage

// File: rtl/ring_out_reg.sv
// ring_out_reg: single-stage valid/ready output register exporting can_load
module ring_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] dat_i,
  input  logic         rdy_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output logic         can_load_o
);
  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;
  always_comb begin
    vld_d = ld_i || (vld_q && !rdy_i);
    dat_d = ld_i ? dat_i : dat_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  assign vld_o = vld_q;
  assign dat_o = dat_q;
  assign can_load_o = !vld_q || rdy_i;
endmodule

// File: rtl/ring_stop_arb.sv
// ring_stop_arb: routes ring flits to eject/next hop and arbitrates local injection with starvation guard
module ring_stop_arb #(
  parameter int WIDTH = ring_pkg::FLIT_W,
  parameter int ID_W = ring_pkg::ID_W,
  parameter int NODE_ID = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iRingEmpty,
  input  logic [WIDTH-1:0] iRingRdDat,
  output logic             oRingRdEn,
  input  logic             iLocEmpty,
  input  logic [WIDTH-1:0] iLocRdDat,
  output logic             oLocRdEn,
  output logic             oNxtVld,
  output logic [WIDTH-1:0] oNxtDat,
  input  logic             iNxtRdy,
  output logic             oEjVld,
  output logic [WIDTH-1:0] oEjDat,
  input  logic             iEjRdy
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [SW-1:0]    starve_q, starve_d;
  logic             nxt_can, ej_can, ring_me, ring_fwd, ring_win, loc_win, ej_ld;
  logic [WIDTH-1:0] nxt_dat;
  // a saturated counter makes the ring ineligible, which hands next hop to local
  always_comb begin
    ring_me = !iRingEmpty && (iRingRdDat[WIDTH-1 -: ID_W] == ID_W'(NODE_ID));
    ring_fwd = !iRingEmpty && !ring_me && (starve_q < SMAX);
    ej_ld = !rst && ring_me && ej_can;
    ring_win = !rst && nxt_can && ring_fwd;
    loc_win = !rst && nxt_can && !ring_fwd && !iLocEmpty;
    starve_d = (iLocEmpty || loc_win) ? '0 : ring_win ? starve_q + 1'b1 : starve_q;
    nxt_dat = ring_win ? iRingRdDat : iLocRdDat;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_q <= '0;
    else starve_q <= starve_d;
  assign oRingRdEn = ej_ld || ring_win;
  assign oLocRdEn = loc_win;
  ring_out_reg #(.W(WIDTH)) u_nxt (
    .clk(clk), .rst(rst), .ld_i(ring_win || loc_win), .dat_i(nxt_dat),
    .rdy_i(iNxtRdy), .vld_o(oNxtVld), .dat_o(oNxtDat), .can_load_o(nxt_can)
  );
  ring_out_reg #(.W(WIDTH)) u_ej (
    .clk(clk), .rst(rst), .ld_i(ej_ld), .dat_i(iRingRdDat),
    .rdy_i(iEjRdy), .vld_o(oEjVld), .dat_o(oEjDat), .can_load_o(ej_can)
  );
endmodule

// File: tb/tb_ring_stop_arb.sv
// tb_ring_stop_arb: random + directed scoreboard bench for ring_stop_arb
module tb_ring_stop_arb;
  localparam int SM = 4;
  logic clk = 0, rst = 1;
  logic iRingEmpty, oRingRdEn, iLocEmpty, oLocRdEn;
  logic oNxtVld, iNxtRdy, oEjVld, iEjRdy;
  logic [7:0] iRingRdDat, iLocRdDat, oNxtDat, oEjDat;
  logic [7:0] ring_q[$], loc_q[$], exp_nxt[$], exp_ej[$];
  int checks = 0, errors = 0;
  bit m_nxt = 0, m_ej = 0, pop_r = 0, pop_l = 0, rnd = 0;
  int m_starve = 0;
  int p_ring = 50, p_loc = 50, p_nrdy = 70, p_erdy = 70, min_dest = 0;
  always #5 clk = ~clk;
  ring_stop_arb #(.WIDTH(8), .ID_W(2), .NODE_ID(0), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .iRingEmpty(iRingEmpty), .iRingRdDat(iRingRdDat), .oRingRdEn(oRingRdEn),
    .iLocEmpty(iLocEmpty), .iLocRdDat(iLocRdDat), .oLocRdEn(oLocRdEn),
    .oNxtVld(oNxtVld), .oNxtDat(oNxtDat), .iNxtRdy(iNxtRdy),
    .oEjVld(oEjVld), .oEjDat(oEjDat), .iEjRdy(iEjRdy)
  );
  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic heads;
    iRingEmpty = ring_q.size() == 0;
    iRingRdDat = iRingEmpty ? 8'h00 : ring_q[0];
    iLocEmpty = loc_q.size() == 0;
    iLocRdDat = iLocEmpty ? 8'h00 : loc_q[0];
  endtask
  // reference: ring flits addressed to node 0 eject, others compete with local for next hop;
  // local gets the slot after SM consecutive ring grants while it waits
  task automatic model_step;
    bit hr, hl, nc, ec, me, fwd, rw, lw, ej;
    logic [7:0] r, l;
    hr = ring_q.size() != 0;
    hl = loc_q.size() != 0;
    r = hr ? ring_q[0] : 8'h00;
    l = hl ? loc_q[0] : 8'h00;
    nc = !m_nxt || iNxtRdy;
    ec = !m_ej || iEjRdy;
    me = hr && (r >> 6) == 0;
    fwd = hr && !me && m_starve < SM;
    ej = me && ec;
    rw = nc && fwd;
    lw = nc && !fwd && hl;
    chk("ring_rden", oRingRdEn, ej || rw);
    chk("loc_rden", oLocRdEn, lw);
    chk("nxt_vld", oNxtVld, m_nxt);
    chk("ej_vld", oEjVld, m_ej);
    if (rw) exp_nxt.push_back(r);
    if (lw) exp_nxt.push_back(l);
    if (ej) exp_ej.push_back(r);
    m_nxt = rw || lw || (m_nxt && !iNxtRdy);
    m_ej = ej || (m_ej && !iEjRdy);
    m_starve = (!hl || lw) ? 0 : rw ? m_starve + 1 : m_starve;
    pop_r = oRingRdEn;
    pop_l = oLocRdEn;
  endtask
  task automatic step;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (pop_r && ring_q.size() != 0) void'(ring_q.pop_front());
    if (pop_l && loc_q.size() != 0) void'(loc_q.pop_front());
    if (rnd) begin
      if (ring_q.size() < 2 && $urandom_range(99) < p_ring)
        ring_q.push_back({2'($urandom_range(3, min_dest)), 6'($urandom)});
      if (loc_q.size() < 2 && $urandom_range(99) < p_loc)
        loc_q.push_back(8'($urandom));
      iNxtRdy = $urandom_range(99) < p_nrdy;
      iEjRdy = $urandom_range(99) < p_erdy;
    end
    heads();
  endtask
  task automatic chk_reset_outputs;
    chk("rst_nxt_vld", oNxtVld, 0);
    chk("rst_nxt_dat", oNxtDat, 0);
    chk("rst_ej_vld", oEjVld, 0);
    chk("rst_ej_dat", oEjDat, 0);
    chk("rst_ring_rden", oRingRdEn, 0);
    chk("rst_loc_rden", oLocRdEn, 0);
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (oNxtVld && iNxtRdy) begin
        if (exp_nxt.size() == 0) chk("nxt_unexpected", oNxtDat, -1);
        else chk("nxt_dat", oNxtDat, exp_nxt.pop_front());
      end
      if (oEjVld && iEjRdy) begin
        if (exp_ej.size() == 0) chk("ej_unexpected", oEjDat, -1);
        else chk("ej_dat", oEjDat, exp_ej.pop_front());
      end
    end
  initial begin
    iNxtRdy = 0;
    iEjRdy = 0;
    ring_q.push_back(8'h05);
    loc_q.push_back(8'h77);
    heads();
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst = 0;
    iNxtRdy = 1;
    iEjRdy = 1;
    step();
    step();
    ring_q.push_back(8'h41);
    ring_q.push_back(8'h42);
    heads();
    repeat (3) step();
    ring_q.push_back(8'h41);
    ring_q.push_back(8'h42);
    heads();
    step();
    step();
    iNxtRdy = 0;
    ring_q.push_back(8'h53);
    heads();
    repeat (3) begin
      step();
      chk("hold_dat", oNxtDat, 8'h42);
    end
    iNxtRdy = 1;
    repeat (3) step();
    iEjRdy = 0;
    ring_q.push_back(8'h05);
    ring_q.push_back(8'h06);
    loc_q.push_back(8'h11);
    loc_q.push_back(8'h22);
    heads();
    repeat (2) step();
    chk("hol_ring_head", iRingRdDat, 8'h06);
    chk("hol_loc_drained", loc_q.size(), 0);
    repeat (2) step();
    iEjRdy = 1;
    repeat (3) step();
    rnd = 1;
    repeat (400) step();
    p_ring = 100; p_loc = 100; p_nrdy = 100; min_dest = 1;
    repeat (40) step();
    p_ring = 60; p_loc = 60; p_nrdy = 60; p_erdy = 40; min_dest = 0;
    repeat (100) step();
    #2;
    rst = 1;
    ring_q.delete(); loc_q.delete(); exp_nxt.delete(); exp_ej.delete();
    m_nxt = 0; m_ej = 0; m_starve = 0;
    ring_q.push_back(8'h45);
    loc_q.push_back(8'h12);
    heads();
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 0;
    p_nrdy = 80; p_erdy = 80;
    repeat (300) step();
    rnd = 0;
    iNxtRdy = 1;
    iEjRdy = 1;
    repeat (10) step();
    chk("drain_nxt", exp_nxt.size(), 0);
    chk("drain_ej", exp_ej.size(), 0);
    chk("drain_fifos", ring_q.size() + loc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
